fault_trip_ctrl: RTL and testbench
==================================

Name: fault_trip_ctrl

Overview:
- Central trip controller for the power unit.
- Collects per-channel filtered fault flags from the delay-filtered error detectors, latches them, and blocks PWM on the first unmasked fault.
- Enforces a minimum lockout time in 1 µs ticks, then accepts a software clear request.
- On an accepted clear, drives the detectors' reset_unit and re-arms only after a settle window passes with no fault.

Parameters:
- N_CH, 8, number of fault channels (2..16).
- LOCK_W, 16, width of lockout_us and the lockout counter.
- RST_CYCLES, 4, length of the reset_unit pulse in clk cycles (>=1).
- SETTLE_US, 10, fault-free settle window after clear, in 1 µs ticks (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- time_1us  in  1  free-running 1 µs square timebase, asynchronous to clk.
- fault_in  in  N_CH  filtered fault flags, 1 = fault.
- fault_mask  in  N_CH  1 = channel ignored for trip and latching.
- lockout_us  in  LOCK_W  minimum time in TRIP/LOCKOUT before a clear is allowed.
- clr_req  in  1  single-cycle clear request pulse.
- pwm_block  out  1  1 = gate drive disabled.
- fault_latched  out  N_CH  sticky record of unmasked faults since the last clear.
- first_fault_id  out  $clog2(N_CH)  index of the channel that caused the trip.
- first_fault_vld  out  1  first_fault_id is valid.
- fault_cnt  out  8  trip counter; saturates at 255; cleared only by reset.
- reset_unit  out  1  synchronous clear to the detectors.
- clr_ack  out  1  one-cycle pulse when re-armed (entering RUN).
- clr_nack  out  1  one-cycle pulse when clr_req is rejected.
- state  out  3  current FSM state, for debug readback.

Behaviour:
- Reset values:
  - Outputs: pwm_block=1, fault_latched=0, first_fault_id=0, first_fault_vld=0, fault_cnt=0, reset_unit=0, clr_ack=0, clr_nack=0.
  - Internal: state=SETTLE with settle counter=0, so the block powers up blocked and self-arms after SETTLE_US fault-free ticks.
- Tick generation:
  - time_1us passes through a 2-flop shift register.
  - tick = 1 for exactly one clk when the register equals 2'b10 (falling edge).
- Fault vector: act = fault_in & ~fault_mask.
- RUN:
  - pwm_block=0.
  - If act != 0, at the next edge:
    - state goes to TRIP and pwm_block=1 (1-clk latency from fault_in to pwm_block).
    - fault_latched |= act.
    - first_fault_id = lowest set index of act; first_fault_vld=1.
    - fault_cnt increments (saturating).
- TRIP: single cycle; clears the lockout counter; goes to LOCKOUT.
- LOCKOUT:
  - The counter increments on tick and saturates at all-ones.
  - Goes to WAIT_CLR when counter >= lockout_us.
  - If lockout_us=0, it exits on the first LOCKOUT cycle.
- WAIT_CLR:
  - On clr_req with act != 0: clr_nack pulse; state is unchanged.
  - On clr_req with act == 0: go to CLEARING.
- CLEARING:
  - reset_unit=1 for exactly RST_CYCLES clk cycles.
  - On entry: fault_latched=0, first_fault_vld=0, first_fault_id=0.
  - Then goes to SETTLE with the settle counter cleared.
- SETTLE:
  - pwm_block stays 1.
  - The counter increments on tick.
  - If act != 0 at any cycle: same actions as a RUN trip (latch, id, count), then go to TRIP.
  - When counter == SETTLE_US with no fault: go to RUN, pwm_block=0, and pulse clr_ack in the same cycle as the RUN entry.
- In TRIP, LOCKOUT, WAIT_CLR and CLEARING:
  - fault_latched |= act continuously, except during CLEARING, where the clear takes precedence.
  - first_fault_id is not overwritten.
- clr_req in any state other than WAIT_CLR: clr_nack pulse, no other effect.
- clr_req in the same cycle act first goes nonzero in WAIT_CLR: rejected (nack).
- Mask changes take effect in the next cycle. Masking an active channel does not clear its latched bit.
- Async reset mid-CLEARING: reset_unit drops immediately, and the FSM restarts in SETTLE.

Decomposition:
- Package power_fault_pkg:
  - FSM state encoding: RUN=0, TRIP=1, LOCKOUT=2, WAIT_CLR=3, CLEARING=4, SETTLE=5.
  - fault_cnt width constant.
  - A function for lowest-set-index priority encoding.
- Sub-module us_tick_gen: 2-flop synchroniser plus 2'b10 edge detector, output tick. It is reused by other timing blocks.

Test Plan:
- Power-up: rst_n low, then high, fault_in=0, SETTLE_US=10 -> pwm_block=1 until the 10th tick; clr_ack pulses once; state=RUN.
- Trip priority: in RUN, fault_in=8'b0010_0100 in one cycle -> pwm_block=1 the next cycle; first_fault_id=2; fault_latched=0x24; fault_cnt=1.
- Lockout: lockout_us=5, then clr_req at tick 3 -> clr_nack. After the 5th tick, with faults deasserted, clr_req -> reset_unit high for 4 clks; fault_latched=0.
- Dirty clear: in WAIT_CLR with fault_in[7]=1, clr_req -> clr_nack; state stays WAIT_CLR.
- Re-trip in settle: fault_in[1] asserted at settle tick 4 -> state TRIP; fault_cnt increments; first_fault_id=1; no clr_ack.
- Mask and saturation: fault_mask=0xFF, toggle fault_in -> no trip. Force 260 trips -> fault_cnt=255.

Source files
------------

// File: rtl/power_fault_pkg.sv
// Shared types and helpers for the power-unit fault/trip logic.
//   trip_state_e   : trip controller FSM encoding (debug-visible)
//   FAULT_CNT_W    : width of the saturating trip counter
//   lowest_set_idx : priority encoder, lowest set bit wins
package power_fault_pkg;

  localparam int unsigned STATE_W     = 3;
  localparam int unsigned FAULT_CNT_W = 8;
  localparam int unsigned MAX_CH      = 16;
  localparam int unsigned MAX_IDX_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 3'd0,
    ST_TRIP     = 3'd1,
    ST_LOCKOUT  = 3'd2,
    ST_WAIT_CLR = 3'd3,
    ST_CLEARING = 3'd4,
    ST_SETTLE   = 3'd5
  } trip_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [MAX_IDX_W-1:0] lowest_set_idx(input logic [MAX_CH-1:0] vec);
    lowest_set_idx = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set_idx = MAX_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// 1 us tick generator: synchronises the free-running time_1us square wave
// into clk and emits a one-clk tick on its falling edge.
//   clk, rst_n : clock, async active-low reset
//   time_1us   : asynchronous 1 us square timebase
//   tick       : 1 for one clk when the synchronised timebase falls
module us_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic time_1us,
  output logic tick
);

  // sync_q[0] is the newest sample, sync_q[1] the older one
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], time_1us};
    end
  end

  assign tick = (sync_q == 2'b10);

endmodule

// File: rtl/fault_trip_ctrl.sv
// Central trip controller: latches unmasked fault flags, blocks PWM on the
// first one, holds a minimum lockout, accepts a software clear, pulses the
// detectors' reset_unit and re-arms after a fault-free settle window.
//   clk, rst_n        : clock, async active-low reset
//   time_1us          : async 1 us timebase
//   fault_in/mask     : per-channel fault flags / ignore mask
//   lockout_us        : minimum lockout in 1 us ticks
//   clr_req           : single-cycle clear request
//   pwm_block         : 1 = gate drive disabled
//   fault_latched     : sticky unmasked faults since last clear
//   first_fault_id/vld: channel that caused the trip
//   fault_cnt         : saturating trip counter
//   reset_unit        : clear pulse to the detectors
//   clr_ack/clr_nack  : re-armed / clear rejected pulses
//   state             : FSM state readback
module fault_trip_ctrl
  import power_fault_pkg::*;
#(
  parameter int unsigned N_CH       = 8,
  parameter int unsigned LOCK_W     = 16,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned SETTLE_US  = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       time_1us,
  input  logic [N_CH-1:0]            fault_in,
  input  logic [N_CH-1:0]            fault_mask,
  input  logic [LOCK_W-1:0]          lockout_us,
  input  logic                       clr_req,
  output logic                       pwm_block,
  output logic [N_CH-1:0]            fault_latched,
  output logic [$clog2(N_CH)-1:0]    first_fault_id,
  output logic                       first_fault_vld,
  output logic [FAULT_CNT_W-1:0]     fault_cnt,
  output logic                       reset_unit,
  output logic                       clr_ack,
  output logic                       clr_nack,
  output logic [STATE_W-1:0]         state
);

  localparam int unsigned ID_W   = $clog2(N_CH);
  localparam int unsigned SET_W  = $clog2(SETTLE_US + 1);
  localparam int unsigned RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic tick;

  us_tick_gen u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .time_1us (time_1us),
    .tick     (tick)
  );

  trip_state_e             state_q, state_d;
  logic                    pwm_block_q, pwm_block_d;
  logic [N_CH-1:0]         latched_q, latched_d;
  logic [ID_W-1:0]         ffid_q, ffid_d;
  logic                    ffvld_q, ffvld_d;
  logic [FAULT_CNT_W-1:0]  fcnt_q, fcnt_d;
  logic                    reset_unit_q, reset_unit_d;
  logic                    clr_ack_q, clr_ack_d;
  logic                    clr_nack_q, clr_nack_d;
  logic [LOCK_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic [SET_W-1:0]        settle_cnt_q, settle_cnt_d;
  logic [RCNT_W-1:0]       rst_cnt_q, rst_cnt_d;
  logic [N_CH-1:0]         act;
  logic                    any_act;

  // Next-state and output decode
  always_comb begin
    act          = fault_in & ~fault_mask;
    any_act      = |act;
    state_d      = state_q;
    pwm_block_d  = pwm_block_q;
    latched_d    = latched_q;
    ffid_d       = ffid_q;
    ffvld_d      = ffvld_q;
    fcnt_d       = fcnt_q;
    reset_unit_d = 1'b0;
    clr_ack_d    = 1'b0;
    lock_cnt_d   = lock_cnt_q;
    settle_cnt_d = settle_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    // Only a clean clear in WAIT_CLR is accepted; anything else is nacked
    clr_nack_d   = clr_req & ~((state_q == ST_WAIT_CLR) & ~any_act);

    if (((state_q == ST_RUN) || (state_q == ST_SETTLE)) && any_act) begin
      state_d     = ST_TRIP;
      pwm_block_d = 1'b1;
      latched_d   = latched_q | act;
      ffid_d      = ID_W'(lowest_set_idx(MAX_CH'(act)));
      ffvld_d     = 1'b1;
      if (fcnt_q != '1) fcnt_d = fcnt_q + FAULT_CNT_W'(1);
    end else begin
      case (state_q)
        ST_RUN: pwm_block_d = 1'b0;
        ST_TRIP: begin
          lock_cnt_d = '0;
          latched_d  = latched_q | act;
          state_d    = ST_LOCKOUT;
        end
        ST_LOCKOUT: begin
          latched_d = latched_q | act;
          if (lock_cnt_q >= lockout_us) state_d = ST_WAIT_CLR;
          if (tick && (lock_cnt_q != '1)) lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
        ST_WAIT_CLR: begin
          if (clr_req && !any_act) begin
            state_d      = ST_CLEARING;
            latched_d    = '0;
            ffid_d       = '0;
            ffvld_d      = 1'b0;
            reset_unit_d = 1'b1;
            rst_cnt_d    = '0;
          end else begin
            latched_d = latched_q | act;
          end
        end
        ST_CLEARING: begin
          // Latch held clear: the clear wins over any fault seen here
          latched_d = '0;
          if (rst_cnt_q == RCNT_W'(RST_CYCLES - 1)) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
          end else begin
            rst_cnt_d    = rst_cnt_q + RCNT_W'(1);
            reset_unit_d = 1'b1;
          end
        end
        ST_SETTLE: begin
          pwm_block_d = 1'b1;
          if (settle_cnt_q == SET_W'(SETTLE_US)) begin
            state_d     = ST_RUN;
            pwm_block_d = 1'b0;
            clr_ack_d   = 1'b1;
          end else if (tick) begin
            settle_cnt_d = settle_cnt_q + SET_W'(1);
          end
        end
        default: begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
          pwm_block_d  = 1'b1;
        end
      endcase
    end
  end

  // State and output registers; power up blocked and self-arming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SETTLE;
      pwm_block_q  <= 1'b1;
      latched_q    <= '0;
      ffid_q       <= '0;
      ffvld_q      <= 1'b0;
      fcnt_q       <= '0;
      reset_unit_q <= 1'b0;
      clr_ack_q    <= 1'b0;
      clr_nack_q   <= 1'b0;
      lock_cnt_q   <= '0;
      settle_cnt_q <= '0;
      rst_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pwm_block_q  <= pwm_block_d;
      latched_q    <= latched_d;
      ffid_q       <= ffid_d;
      ffvld_q      <= ffvld_d;
      fcnt_q       <= fcnt_d;
      reset_unit_q <= reset_unit_d;
      clr_ack_q    <= clr_ack_d;
      clr_nack_q   <= clr_nack_d;
      lock_cnt_q   <= lock_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
    end
  end

  assign pwm_block       = pwm_block_q;
  assign fault_latched   = latched_q;
  assign first_fault_id  = ffid_q;
  assign first_fault_vld = ffvld_q;
  assign fault_cnt       = fcnt_q;
  assign reset_unit      = reset_unit_q;
  assign clr_ack         = clr_ack_q;
  assign clr_nack        = clr_nack_q;
  assign state           = state_q;

endmodule

// File: tb/tb_fault_trip_ctrl.sv
// Self-checking bench for fault_trip_ctrl: scenario tasks plus randomized
// traffic, compared against a behavioural model of the trip rules.
module tb_fault_trip_ctrl;

  localparam int N_CH       = 8;
  localparam int LOCK_W     = 16;
  localparam int RST_CYCLES = 4;
  localparam int SETTLE_US  = 10;
  localparam int S_RUN = 0, S_TRIP = 1, S_LOCK = 2, S_WAIT = 3, S_CLR = 4, S_SETTLE = 5;

  logic        clk = 1'b0;
  logic        rst_n, time_1us, clr_req;
  logic [7:0]  fault_in, fault_mask;
  logic [15:0] lockout_us;
  logic        pwm_block, first_fault_vld, reset_unit, clr_ack, clr_nack;
  logic [7:0]  fault_latched, fault_cnt;
  logic [2:0]  first_fault_id, state;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_half = 3;
  int tick_ph   = 0;

  // Reference model of the controller's observable behaviour
  int         m_state, m_id, m_cnt, m_lock, m_settle, m_clr_left, m_trips;
  bit         m_pwm, m_vld, m_ru, m_ack, m_nack, s1, s2;
  logic [7:0] m_lat;

  always #5 clk = ~clk;

  fault_trip_ctrl #(
    .N_CH(N_CH), .LOCK_W(LOCK_W), .RST_CYCLES(RST_CYCLES), .SETTLE_US(SETTLE_US)
  ) dut (
    .clk(clk), .rst_n(rst_n), .time_1us(time_1us),
    .fault_in(fault_in), .fault_mask(fault_mask), .lockout_us(lockout_us),
    .clr_req(clr_req), .pwm_block(pwm_block), .fault_latched(fault_latched),
    .first_fault_id(first_fault_id), .first_fault_vld(first_fault_vld),
    .fault_cnt(fault_cnt), .reset_unit(reset_unit), .clr_ack(clr_ack),
    .clr_nack(clr_nack), .state(state)
  );

  logic [26:0] dut_vec;
  assign dut_vec = {pwm_block, fault_latched, first_fault_id, first_fault_vld,
                    fault_cnt, reset_unit, clr_ack, clr_nack, state};

  function automatic logic [26:0] exp_vec();
    return {m_pwm, m_lat, 3'(m_id), m_vld, 8'(m_cnt), m_ru, m_ack, m_nack, 3'(m_state)};
  endfunction

  function automatic int lowest_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = S_SETTLE; m_pwm = 1; m_lat = '0; m_id = 0; m_vld = 0; m_cnt = 0;
    m_ru = 0; m_ack = 0; m_nack = 0; m_lock = 0; m_settle = 0; m_clr_left = 0;
    s1 = 0; s2 = 0;
  endtask

  // One clock of the trip rules, using the inputs seen at this edge
  task automatic model_step();
    logic [7:0] a;
    bit tk, clean_clr;
    a  = fault_in & ~fault_mask;
    tk = s2 && !s1;
    s2 = s1;
    s1 = time_1us;
    clean_clr = clr_req && (m_state == S_WAIT) && (a == 0);
    m_nack = clr_req && !clean_clr;
    m_ack  = 0;
    if ((m_state == S_RUN || m_state == S_SETTLE) && a != 0) begin
      m_lat = m_lat | a; m_id = lowest_idx(a); m_vld = 1; m_pwm = 1;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_state = S_TRIP; m_trips++;
    end else if (m_state == S_RUN) begin
      m_pwm = 0;
    end else if (m_state == S_SETTLE) begin
      if (m_settle == SETTLE_US) begin m_state = S_RUN; m_pwm = 0; m_ack = 1; end
      else if (tk) m_settle++;
    end else if (m_state == S_TRIP) begin
      m_lat = m_lat | a; m_lock = 0; m_state = S_LOCK;
    end else if (m_state == S_LOCK) begin
      m_lat = m_lat | a;
      if (m_lock >= int'(lockout_us)) m_state = S_WAIT;
      if (tk && m_lock < 65535) m_lock++;
    end else if (m_state == S_WAIT) begin
      if (clean_clr) begin
        m_state = S_CLR; m_lat = '0; m_vld = 0; m_id = 0; m_ru = 1; m_clr_left = RST_CYCLES;
      end else m_lat = m_lat | a;
    end else begin
      m_clr_left--;
      if (m_clr_left == 0) begin m_ru = 0; m_state = S_SETTLE; m_settle = 0; end
    end
  endtask

  // Advance one clock; clr_req is a single-cycle pulse
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    clr_req = 1'b0;
    if (tick_half == 0) time_1us = 1'($urandom_range(0, 1));
    else begin
      tick_ph++;
      if (tick_ph >= tick_half) begin tick_ph = 0; time_1us = ~time_1us; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fault_in = '0; fault_mask = '0; lockout_us = 16'd5;
    clr_req = 1'b0; time_1us = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (dut_vec !== {1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd5}) begin
      n_fail++; $display("FAIL reset_values got=%h want=%h", dut_vec,
        {1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd5});
    end
    n_tests++;
    if (pwm_block !== 1'b1) begin n_fail++; $display("FAIL reset_pwm got=%b want=1", pwm_block); end
    rst_n = 1'b1;
  endtask

  task automatic test_powerup();
    int acks = 0;
    int cyc  = 0;
    bit seen_run = 0;
    while (!seen_run && cyc < 400) begin
      cycle(); cyc++;
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL powerup_vec t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
      if (clr_ack) acks++;
      if (state == 3'd0) seen_run = 1;
    end
    n_tests++;
    if (!seen_run) begin n_fail++; $display("FAIL powerup_timeout got_state=%0d want=0", state); end
    repeat (5) begin
      cycle();
      if (clr_ack) acks++;
    end
    n_tests++;
    if (acks != 1) begin n_fail++; $display("FAIL powerup_ack_count got=%0d want=1", acks); end
    n_tests++;
    if (pwm_block !== 1'b0) begin n_fail++; $display("FAIL powerup_pwm got=%b want=0", pwm_block); end
  endtask

  task automatic test_trip_priority();
    fault_in = 8'b0010_0100;
    cycle();
    fault_in = '0;
    n_tests++;
    if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL trip_vec got=%h want=%h", dut_vec, exp_vec()); end
    n_tests++;
    if (pwm_block !== 1'b1) begin n_fail++; $display("FAIL trip_pwm got=%b want=1", pwm_block); end
    n_tests++;
    if (first_fault_id !== 3'd2) begin n_fail++; $display("FAIL trip_id got=%0d want=2", first_fault_id); end
    n_tests++;
    if (fault_latched !== 8'h24) begin n_fail++; $display("FAIL trip_latched got=%h want=24", fault_latched); end
    n_tests++;
    if (fault_cnt !== 8'd1 || state !== 3'd1) begin
      n_fail++; $display("FAIL trip_cnt_state got=%0d/%0d want=1/1", fault_cnt, state);
    end
  endtask

  task automatic test_lockout();
    int budget = 0;
    int ru_cnt = 0;
    while (!(m_state == S_LOCK && m_lock >= 3) && budget < 200) begin
      cycle(); budget++;
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL lockout_vec got=%h want=%h", dut_vec, exp_vec()); end
    end
    clr_req = 1'b1;
    cycle();
    n_tests++;
    if (clr_nack !== 1'b1 || state !== 3'd2) begin
      n_fail++; $display("FAIL lockout_early_clr got nack=%b state=%0d want 1/2", clr_nack, state);
    end
    budget = 0;
    while (state !== 3'd3 && budget < 200) begin
      cycle(); budget++;
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL lockout_wait_vec got=%h want=%h", dut_vec, exp_vec()); end
    end
    n_tests++;
    if (state !== 3'd3) begin n_fail++; $display("FAIL lockout_timeout got_state=%0d want=3", state); end
    clr_req = 1'b1;
    cycle();
    n_tests++;
    if (state !== 3'd4 || reset_unit !== 1'b1 || fault_latched !== 8'h00 || first_fault_vld !== 1'b0) begin
      n_fail++; $display("FAIL clear_entry got state=%0d ru=%b lat=%h vld=%b want 4/1/00/0",
                         state, reset_unit, fault_latched, first_fault_vld);
    end
    budget = 0;
    while (state !== 3'd5 && budget < 20) begin
      if (reset_unit) ru_cnt++;
      cycle(); budget++;
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL clearing_vec got=%h want=%h", dut_vec, exp_vec()); end
    end
    n_tests++;
    if (ru_cnt != RST_CYCLES) begin n_fail++; $display("FAIL reset_unit_len got=%0d want=%0d", ru_cnt, RST_CYCLES); end
  endtask

  task automatic test_retrip_settle();
    int budget = 0;
    while (m_settle < 4 && budget < 200) begin
      cycle(); budget++;
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL settle_vec got=%h want=%h", dut_vec, exp_vec()); end
    end
    fault_in = 8'h02;
    cycle();
    fault_in = '0;
    n_tests++;
    if (state !== 3'd1 || fault_cnt !== 8'd2 || first_fault_id !== 3'd1 || clr_ack !== 1'b0) begin
      n_fail++; $display("FAIL retrip got state=%0d cnt=%0d id=%0d ack=%b want 1/2/1/0",
                         state, fault_cnt, first_fault_id, clr_ack);
    end
  endtask

  task automatic test_dirty_clear();
    int budget = 0;
    int acks = 0;
    lockout_us = 16'd0;
    cycle();
    n_tests++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL zero_lock_enter got=%0d want=2", state); end
    cycle();
    n_tests++;
    if (state !== 3'd3) begin n_fail++; $display("FAIL zero_lock_exit got=%0d want=3", state); end
    fault_in = 8'h80;
    clr_req  = 1'b1;
    cycle();
    n_tests++;
    if (clr_nack !== 1'b1 || state !== 3'd3 || fault_latched !== 8'h82) begin
      n_fail++; $display("FAIL dirty_clear got nack=%b state=%0d lat=%h want 1/3/82", clr_nack, state, fault_latched);
    end
    fault_in = '0;
    cycle();
    clr_req = 1'b1;
    cycle();
    n_tests++;
    if (state !== 3'd4) begin n_fail++; $display("FAIL clean_clear got=%0d want=4", state); end
    while (state !== 3'd0 && budget < 300) begin
      cycle(); budget++;
      if (clr_ack) acks++;
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL rearm_vec got=%h want=%h", dut_vec, exp_vec()); end
    end
    n_tests++;
    if (acks != 1) begin n_fail++; $display("FAIL rearm_ack got=%0d want=1", acks); end
  endtask

  task automatic test_mask_sat();
    int budget = 0;
    fault_mask = 8'hFF;
    repeat (20) begin
      fault_in = 8'($urandom);
      cycle();
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL mask_vec got=%h want=%h", dut_vec, exp_vec()); end
    end
    n_tests++;
    if (state !== 3'd0 || pwm_block !== 1'b0) begin
      n_fail++; $display("FAIL mask_no_trip got state=%0d pwm=%b want 0/0", state, pwm_block);
    end
    fault_mask = '0; fault_in = '0; tick_half = 1; m_trips = 0;
    while (m_trips < 260 && budget < 8000) begin
      if (m_state == S_RUN || m_state == S_SETTLE) fault_in = 8'($urandom_range(1, 255));
      else if (m_state == S_WAIT) begin fault_in = '0; clr_req = 1'b1; end
      else fault_in = 8'($urandom);
      cycle(); budget++;
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL sat_vec got=%h want=%h", dut_vec, exp_vec()); end
    end
    fault_in = '0;
    n_tests++;
    if (fault_cnt !== 8'd255 || m_trips < 260) begin
      n_fail++; $display("FAIL saturation got=%0d want=255 (trips %0d)", fault_cnt, m_trips);
    end
  endtask

  task automatic test_async_reset_clearing();
    int budget = 0;
    fault_in = '0;
    while (m_state != S_WAIT && budget < 50) begin cycle(); budget++; end
    clr_req = 1'b1;
    cycle();
    n_tests++;
    if (reset_unit !== 1'b1 || state !== 3'd4) begin
      n_fail++; $display("FAIL pre_reset_clear got ru=%b state=%0d want 1/4", reset_unit, state);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (reset_unit !== 1'b0 || state !== 3'd5 || pwm_block !== 1'b1 || fault_cnt !== 8'd0) begin
      n_fail++; $display("FAIL async_reset got ru=%b state=%0d pwm=%b cnt=%0d want 0/5/1/0",
                         reset_unit, state, pwm_block, fault_cnt);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick_half = 3; tick_ph = 0;
    repeat (80) begin
      cycle();
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL post_reset_vec got=%h want=%h", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_random();
    tick_half = 0;
    repeat (3000) begin
      fault_in = ($urandom_range(0, 99) < 2) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 31) == 0) fault_mask = 8'($urandom) & 8'($urandom);
      clr_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) lockout_us = 16'($urandom_range(0, 4));
      cycle();
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL random_vec t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_trip_priority();
    test_lockout();
    test_retrip_settle();
    test_dirty_clear();
    test_mask_sat();
    test_async_reset_clearing();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
